// File: rtl/cmsdk_mcu_systick_pkg.sv
// Shared constants for the SysTick APB timer.
//   - register byte offsets (decoded on PADDR[11:2])
//   - CSR bit positions
//   - counter width
package cmsdk_mcu_systick_pkg;

    localparam int CNT_W = 24;

    localparam int unsigned CSR_OFS   = 32'h000;
    localparam int unsigned RVR_OFS   = 32'h004;
    localparam int unsigned CVR_OFS   = 32'h008;
    localparam int unsigned CALIB_OFS = 32'h00C;

    localparam int CSR_ENABLE    = 0;
    localparam int CSR_TICKINT   = 1;
    localparam int CSR_CLKSOURCE = 2;
    localparam int CSR_COUNTFLAG = 16;

    typedef struct packed {
        logic csr;
        logic rvr;
        logic cvr;
        logic calib;
    } reg_hit_t;

endpackage

// File: rtl/cmsdk_mcu_systick_apb_if.sv
// APB3 slave bus bundle for the SysTick timer.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : requester -> timer
//   PRDATA/PREADY/PSLVERR            : timer -> requester
// PADDR carries the word address (byte address bits [ADDR_W-1:2]).
interface cmsdk_mcu_systick_apb_if #(
    parameter int ADDR_W = 12
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:2] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/cmsdk_mcu_systick_refedge.sv
// Rising-edge detector for the divider's STCLKEN toggle level.
//   FCLK, SYSRESETn : clock, async active-low reset
//   STCLKEN         : toggle level, already in the FCLK domain
//   ref_tick        : one-cycle pulse on each 0->1 transition of STCLKEN
// No synchroniser: the divider runs on FCLK.
module cmsdk_mcu_systick_refedge (
    input  logic FCLK,
    input  logic SYSRESETn,
    input  logic STCLKEN,
    output logic ref_tick
);
    logic stclken_q;

    always_ff @(posedge FCLK or negedge SYSRESETn) begin
        if (!SYSRESETn) stclken_q <= 1'b0;
        else            stclken_q <= STCLKEN;
    end

    assign ref_tick = STCLKEN & ~stclken_q;
endmodule

// File: rtl/cmsdk_mcu_systick_apb.sv
// SysTick-compatible 24-bit down-counter on APB.
//   FCLK, SYSRESETn : clock, async active-low reset
//   apb             : APB slave (CSR 0x0, RVR 0x4, CVR 0x8, CALIB 0xC)
//   STCLKEN         : reference toggle level from the divider
//   STCALIB         : {NOREF, SKEW, TENMS[23:0]}
//   TICKIRQ         : registered one-cycle pulse when CVR goes 1->0 with TICKINT
module cmsdk_mcu_systick_apb
    import cmsdk_mcu_systick_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                    FCLK,
    input  logic                    SYSRESETn,
    cmsdk_mcu_systick_apb_if.slave  apb,
    input  logic                    STCLKEN,
    input  logic [25:0]             STCALIB,
    output logic                    TICKIRQ
);
    logic             enable;
    logic             tickint;
    logic             clksrc_r;
    logic             countflag;
    logic [CNT_W-1:0] rvr;
    logic [CNT_W-1:0] cvr;

    logic             noref;
    logic             clksource;
    logic             ref_tick;
    logic             tick;
    logic             flag_set;
    logic             acc, wr, rd;
    reg_hit_t         hit;
    logic [31:0]      rdata;
    logic             unused_ok;

    cmsdk_mcu_systick_refedge u_refedge (
        .FCLK      (FCLK),
        .SYSRESETn (SYSRESETn),
        .STCLKEN   (STCLKEN),
        .ref_tick  (ref_tick)
    );

    // Without a reference clock the counter can only run from FCLK.
    assign noref     = STCALIB[25];
    assign clksource = noref | clksrc_r;

    assign acc = apb.PSEL & apb.PENABLE;
    assign wr  = acc & apb.PWRITE;
    assign rd  = acc & ~apb.PWRITE;

    assign hit.csr   = (apb.PADDR == (ADDR_W-2)'(CSR_OFS   >> 2));
    assign hit.rvr   = (apb.PADDR == (ADDR_W-2)'(RVR_OFS   >> 2));
    assign hit.cvr   = (apb.PADDR == (ADDR_W-2)'(CVR_OFS   >> 2));
    assign hit.calib = (apb.PADDR == (ADDR_W-2)'(CALIB_OFS >> 2));

    assign tick = enable & (clksource | ref_tick);

    // A CVR write in the same cycle suppresses the 1->0 event entirely.
    assign flag_set = tick & (cvr == CNT_W'(1)) & ~(wr & hit.cvr);

    always_ff @(posedge FCLK or negedge SYSRESETn) begin
        if (!SYSRESETn) begin
            enable    <= 1'b0;
            tickint   <= 1'b0;
            clksrc_r  <= 1'b0;
            countflag <= 1'b0;
            rvr       <= '0;
            cvr       <= '0;
            TICKIRQ   <= 1'b0;
        end else begin
            if (wr && hit.csr) begin
                enable  <= apb.PWDATA[CSR_ENABLE];
                tickint <= apb.PWDATA[CSR_TICKINT];
                if (!noref) clksrc_r <= apb.PWDATA[CSR_CLKSOURCE];
            end

            if (wr && hit.rvr) rvr <= apb.PWDATA[CNT_W-1:0];

            // Reload uses the pre-edge RVR, so a same-cycle RVR write lands next period.
            if (wr && hit.cvr)  cvr <= '0;
            else if (tick)      cvr <= (cvr == '0) ? rvr : cvr - 1'b1;

            // Set beats read-clear; CVR write beats both.
            if (wr && hit.cvr)         countflag <= 1'b0;
            else if (flag_set)         countflag <= 1'b1;
            else if (rd && hit.csr)    countflag <= 1'b0;

            TICKIRQ <= flag_set & tickint;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit.csr) begin
            rdata[CSR_ENABLE]    = enable;
            rdata[CSR_TICKINT]   = tickint;
            rdata[CSR_CLKSOURCE] = clksource;
            rdata[CSR_COUNTFLAG] = countflag;
        end else if (hit.rvr) begin
            rdata[CNT_W-1:0] = rvr;
        end else if (hit.cvr) begin
            rdata[CNT_W-1:0] = cvr;
        end else if (hit.calib) begin
            rdata = {STCALIB[25], STCALIB[24], 6'b0, STCALIB[23:0]};
        end
    end

    assign apb.PRDATA  = rd ? rdata : 32'h0;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    assign unused_ok = ^apb.PWDATA[31:CNT_W];
endmodule

// File: tb/tb_cmsdk_mcu_systick_apb.sv
module tb_cmsdk_mcu_systick_apb;
    logic        FCLK = 1'b0;
    logic        SYSRESETn = 1'b0;
    logic        STCLKEN = 1'b0;
    logic [25:0] STCALIB = 26'h100_0000;
    logic        TICKIRQ;

    cmsdk_mcu_systick_apb_if #(.ADDR_W(12)) apb ();

    cmsdk_mcu_systick_apb #(.ADDR_W(12)) dut (
        .FCLK      (FCLK),
        .SYSRESETn (SYSRESETn),
        .apb       (apb.slave),
        .STCLKEN   (STCLKEN),
        .STCALIB   (STCALIB),
        .TICKIRQ   (TICKIRQ)
    );

    always #5 FCLK = ~FCLK;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int ref_div = 0;
    int ref_cnt = 0;

    // Reference model: CVR is derived from how many ticks have occurred since
    // the count last started from 0; period of the down-count is RVR+1 ticks.
    int m_ticks;
    int m_rvr;
    bit m_en, m_tickint, m_clk_r, m_flag, m_irq, m_stc_prev;

    function automatic bit m_clk();
        return STCALIB[25] | m_clk_r;
    endfunction

    function automatic int exp_cvr();
        if (m_ticks == 0) return 0;
        return m_rvr - ((m_ticks - 1) % (m_rvr + 1));
    endfunction

    function automatic logic [31:0] exp_reg(int w);
        case (w)
            0: return (32'(m_flag) << 16) | (32'(m_clk()) << 2) | (32'(m_tickint) << 1) | 32'(m_en);
            1: return 32'(m_rvr);
            2: return 32'(exp_cvr());
            3: return {STCALIB[25], STCALIB[24], 6'b0, STCALIB[23:0]};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge FCLK or negedge SYSRESETn) begin : model
        bit acc, tick, set, wcvr;
        int w;
        if (!SYSRESETn) begin
            m_ticks = 0; m_rvr = 0; m_en = 0; m_tickint = 0; m_clk_r = 0;
            m_flag = 0; m_irq = 0; m_stc_prev = 0;
        end else begin
            acc  = apb.PSEL && apb.PENABLE;
            w    = int'(apb.PADDR);
            wcvr = acc && apb.PWRITE && (w == 2);
            tick = m_en && (m_clk() || (STCLKEN && !m_stc_prev));
            set  = 0;
            if (wcvr) m_ticks = 0;
            else if (tick) begin
                m_ticks++;
                if (m_rvr != 0 && (m_ticks % (m_rvr + 1)) == 0) set = 1;
            end
            m_irq = set && m_tickint;
            if (wcvr) m_flag = 0;
            else if (set) m_flag = 1;
            else if (acc && !apb.PWRITE && w == 0) m_flag = 0;
            if (acc && apb.PWRITE && w == 0) begin
                m_en      = apb.PWDATA[0];
                m_tickint = apb.PWDATA[1];
                if (!STCALIB[25]) m_clk_r = apb.PWDATA[2];
            end
            if (acc && apb.PWRITE && w == 1) m_rvr = int'(apb.PWDATA[23:0]);
            m_stc_prev = STCLKEN;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge FCLK);
        if (ref_div != 0) begin
            ref_cnt++;
            if (ref_cnt >= ref_div) begin
                ref_cnt = 0;
                STCLKEN = ~STCLKEN;
            end
        end
        #1;
        chk("tickirq", 32'(TICKIRQ), 32'(m_irq));
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(int w, logic [31:0] d);
        apb.PSEL = 1; apb.PWRITE = 1; apb.PENABLE = 0;
        apb.PADDR = 10'(w); apb.PWDATA = d;
        step();
        apb.PENABLE = 1;
        step();
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
    endtask

    // use_m: expected value from the model; otherwise the constant c.
    task automatic rd(int w, bit use_m, logic [31:0] c, string tag);
        logic [31:0] e;
        apb.PSEL = 1; apb.PWRITE = 0; apb.PENABLE = 0; apb.PADDR = 10'(w);
        step();
        apb.PENABLE = 1;
        #1;
        e = use_m ? exp_reg(w) : c;
        chk(tag, apb.PRDATA, e);
        step();
        apb.PSEL = 0; apb.PENABLE = 0;
        #1;
        chk("prdata_idle", apb.PRDATA, 32'h0);
    endtask

    task automatic restart(int n, logic [31:0] csr);
        wr(0, 32'h0);
        wr(2, 32'h0);
        wr(1, 32'(n));
        wr(0, csr);
    endtask

    initial begin : stim
        int cnt;
        int n;
        bit ok;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
        #12;
        chk("rst_irq", 32'(TICKIRQ), 32'h0);
        chk("rst_prdata", apb.PRDATA, 32'h0);
        @(negedge FCLK);
        SYSRESETn = 1;
        #1;

        // Reset values
        rd(0, 0, 32'h0, "rst_csr");
        rd(1, 0, 32'h0, "rst_rvr");
        rd(2, 0, 32'h0, "rst_cvr");
        rd(3, 0, 32'h4000_0000, "rst_calib");
        rd(5, 0, 32'h0, "unmapped");

        // FCLK source, RVR=4: pulse every 5 cycles, flag read-to-clear
        restart(4, 32'h7);
        for (int i = 0; i < 4; i++) rd(2, 1, 0, "cvr_fclk");
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (TICKIRQ) cnt++;
        end
        chk("irq_count_fclk", 32'(cnt), 32'd10);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = TICKIRQ;
        end
        chk("irq_seen", 32'(ok), 32'h1);
        rd(0, 0, 32'h0001_0007, "csr_flag_set");
        rd(0, 0, 32'h0000_0007, "csr_flag_clr");

        // Reference source: STCLKEN toggles every 500, RVR=2
        ref_div = 500;
        restart(2, 32'h3);
        steps(3500);
        rd(2, 1, 0, "cvr_ref_a");
        steps(1000);
        rd(2, 1, 0, "cvr_ref_b");
        cnt = 0;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (TICKIRQ) cnt++;
        end
        chk("irq_count_ref", 32'(cnt), 32'd2);
        rd(0, 1, 0, "csr_ref");
        ref_div = 0;

        // NOREF forces CLKSOURCE
        wr(0, 32'h0);
        STCALIB = 26'h200_1234;
        restart(3, 32'h1);
        rd(0, 0, 32'h5, "csr_noref");
        rd(3, 0, 32'h8000_1234, "calib_noref");
        steps(9);
        rd(2, 1, 0, "cvr_noref");
        rd(0, 1, 0, "csr_noref_flag");
        wr(0, 32'h0);
        STCALIB = 26'h100_0000;

        // CVR write colliding with the 1->0 transition
        restart(5, 32'h7);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = (exp_cvr() == 2);
        end
        chk("collide_sync", 32'(ok), 32'h1);
        wr(2, 32'h0);
        chk("collide_irq", 32'(TICKIRQ), 32'h0);
        rd(2, 0, 32'd5, "collide_reload");
        rd(0, 0, 32'h7, "collide_flag");

        // RVR=0 never flags or interrupts
        restart(0, 32'h7);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (TICKIRQ) cnt++;
        end
        chk("rvr0_irq", 32'(cnt), 32'h0);
        rd(0, 0, 32'h7, "rvr0_csr");
        rd(2, 0, 32'h0, "rvr0_cvr");

        // Randomised reloads and read points
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 12);
            restart(n, 32'h5 | (32'($urandom_range(0, 1)) << 1));
            for (int j = 0; j < 6; j++) begin
                steps($urandom_range(0, 2 * n + 3));
                rd($urandom_range(0, 3), 1, 0, "rand_reg");
            end
        end

        // Asynchronous reset mid-count
        restart(32'h123456, 32'h7);
        steps(3);
        rd(2, 1, 0, "cvr_big");
        #2;
        SYSRESETn = 0;
        #1;
        chk("arst_irq", 32'(TICKIRQ), 32'h0);
        steps(3);
        SYSRESETn = 1;
        steps(2);
        rd(0, 0, 32'h0, "arst_csr");
        rd(2, 0, 32'h0, "arst_cvr");
        rd(1, 0, 32'h0, "arst_rvr");
        steps(10);
        rd(2, 0, 32'h0, "arst_idle_cvr");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
